fifo_serializer: RTL and testbench
==================================

# fifo_serializer

Downstream consumer for the same-clock FIFO. It pops wide words (`OUT_WIDTH << RATIO_LOG` bits) from the FIFO read port and emits them as `OUT_WIDTH`-bit chunks, least-significant chunk first, on a valid/ready stream. Each transfer is a burst of `len` words started by a command pulse, and completion is reported with `done`. Typical use: unloading a 64-bit FIFO into a 16-bit command/data bus.

## Interface

Parameters:
- `OUT_WIDTH`, 16, output chunk width.
- `RATIO_LOG`, 2, log2 of chunks per FIFO word (RATIO = 4); FIFO word width `IN_WIDTH = OUT_WIDTH << RATIO_LOG`.
- `CNT_WIDTH`, 10, width of the burst length, in words.

Ports:
- `clk`  in  1  clock, positive edge.
- `rst_n`  in  1  reset, asynchronous, active-low; one clock, so every register is in the `clk` domain.
- `start`  in  1  command pulse; accepted only while `busy` = 0.
- `abort`  in  1  synchronous cancel of the burst in progress.
- `len`  in  CNT_WIDTH  number of FIFO words in the burst; sampled when `start` is accepted.
- `fifo_nempty`  in  1  FIFO has data; `fifo_data` is valid while this is high.
- `fifo_data`  in  IN_WIDTH  FIFO head word (FIFO `data_out`).
- `fifo_re`  out  1  pop FIFO head at this clock edge (drives FIFO `re`).
- `dout`  out  OUT_WIDTH  output chunk.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  sink accepts `dout`.
- `dout_last`  out  1  current chunk is the final chunk of the burst.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse after the burst completes.

## Operation

- State registers:
  - `fetch_left` [CNT_WIDTH]: words not yet popped.
  - `have`: shift register holds a word.
  - `sub` [RATIO_LOG]: index of the current chunk.
  - `sr` [IN_WIDTH]: shift register.
- IDLE (`busy`=0):
  - `start` & `len`≠0 → `busy`←1, `fetch_left`←`len`.
  - `start` & `len`=0 → `done`←1 next cycle; `busy` stays 0.
- Handshake: `hs = dout_valid & dout_ready`.
- Pop condition: `fifo_re = busy & fifo_nempty & fetch_left≠0 & (!have | (hs & sub==RATIO-1))`.
  - `fifo_re` is combinational and is never high while `fifo_nempty`=0.
- On `fifo_re`:
  - `sr`←`fifo_data`, `have`←1, `sub`←0, `fetch_left`←`fetch_left`-1.
  - This edge is the FIFO pop edge.
- On `hs` with `sub`<RATIO-1: `sub`←`sub`+1; `dout` shows `sr[sub*OUT_WIDTH +: OUT_WIDTH]`.
- On `hs` with `sub`=RATIO-1 and no pop in the same cycle: `have`←0.
- Output signals:
  - `dout_valid` = `have`.
  - `dout_last` = `have` & `fetch_left`=0 & `sub`=RATIO-1.
  - `dout` is 0 when `have`=0.
- Burst completion: `hs` & `dout_last` → `busy`←0, `have`←0, and `done`=1 on the next cycle.
- `abort` while `busy`:
  - Next cycle `busy`=0, `have`=0, `fetch_left`=0; no `done`.
  - Words already popped are discarded; the remainder stays in the FIFO.
  - `abort` in the same cycle as `start` cancels the start.
- `start` while `busy` is ignored; `len` is not resampled.
- A FIFO underrun (`fifo_nempty`=0 mid-burst) stalls the block with `dout_valid`=0. There is no timeout.
- `dout_ready` may toggle freely. `dout` is held stable while `dout_valid` & !`dout_ready`.
- `sub` wraps modulo RATIO. All counters are unsigned and never go below 0.

## Timing

- Reset values: `fifo_re`=0, `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0; all internal counters are 0.
- Reset deassertion is taken asynchronously. The first accepted `start` is at the first rising edge with `rst_n`=1.
- Latency with FIFO non-empty:
  - `start` at edge 0 → `busy`=1 after edge 0.
  - `fifo_re`=1 in the cycle after edge 0 → chunk 0 valid after edge 1.
- Throughput: one chunk per cycle with `dout_ready` held at 1. The next word is popped on the handshake of the last chunk, so there are no bubbles between words.
- Burst of N words with the sink always ready: the last handshake is at cycle 1+N·RATIO, and `done` is high in the following cycle.
- `rst_n` asserted mid-burst clears everything immediately. Popped data is lost, and `fifo_re` drops without waiting for the clock.

## Test plan

- `len`=1, FIFO holds 0x4444_3333_2222_1111, `dout_ready`=1 → `dout` 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; `dout_last` only on 0x4444; `done` 1 cycle later; exactly one `fifo_re`.
- `len`=3, FIFO pre-filled with 3 words, `dout_ready`=1 → 12 chunks with no gap; `fifo_re` coincides with every 4th handshake; `busy` high for 13 cycles.
- `len`=2, `dout_ready` random 50% → chunk order preserved; `dout` stable while stalled; 8 handshakes total; `done` exactly once.
- `len`=2 with the FIFO empty at start, then 1 word at cycle 5 and 1 at cycle 20 → `dout_valid` low while starved; `fifo_re` is never high with `fifo_nempty`=0; 8 chunks delivered.
- `start` with `len`=0 → `done` next cycle, `busy`=0 throughout, no `fifo_re`. `start` asserted while `busy` → ignored.
- `abort` after chunk 1 of word 1 of a `len`=4 burst → `busy`=0 next cycle, no `done`, 3 words left in the FIFO. `rst_n` pulsed mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops wide words from a same-clock FIFO and streams them out
// as OUT_WIDTH-bit chunks, least-significant chunk first, over valid/ready.
// A burst of `len` words is launched by `start`; `done` pulses once after the
// final chunk of the burst is accepted. `abort` drops the burst without `done`.
module fifo_serializer #(
  parameter int OUT_WIDTH = 16,
  parameter int RATIO_LOG = 2,
  parameter int CNT_WIDTH = 10,
  localparam int IN_WIDTH = OUT_WIDTH << RATIO_LOG,
  localparam int RATIO    = 1 << RATIO_LOG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 fifo_nempty,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  output logic                 fifo_re,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [RATIO_LOG-1:0] SUB_LAST = {RATIO_LOG{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   fetch_left_reg, fetch_left_next;
  logic                   have_reg, have_next;
  logic [RATIO_LOG-1:0]   sub_reg, sub_next;
  logic [IN_WIDTH-1:0]    sr_reg, sr_next;
  logic                   done_reg, done_next;

  logic                   hs;
  logic                   sub_at_last;
  logic [OUT_WIDTH-1:0]   chunk [RATIO];

  // Slice the shift register into its output chunks; chunk 0 is the LSBs.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_chunk
      assign chunk[gi] = sr_reg[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // State register: every register clears asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      fetch_left_reg <= '0;
      have_reg       <= 1'b0;
      sub_reg        <= '0;
      sr_reg         <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_left_reg <= fetch_left_next;
      have_reg       <= have_next;
      sub_reg        <= sub_next;
      sr_reg         <= sr_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic: burst launch, word pops, chunk stepping, completion, abort.
  always_comb begin
    state_next      = state_reg;
    fetch_left_next = fetch_left_reg;
    have_next       = have_reg;
    sub_next        = sub_reg;
    sr_next         = sr_reg;
    done_next       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // abort in the same cycle cancels the command entirely (no done either)
        if (start && !abort) begin
          if (len != '0) begin
            state_next      = ST_BUSY;
            fetch_left_next = len;
            have_next       = 1'b0;
            sub_next        = '0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (abort) begin
          state_next      = ST_IDLE;
          have_next       = 1'b0;
          fetch_left_next = '0;
          sub_next        = '0;
        end else begin
          // A pop on the last-chunk handshake reloads the register in place,
          // which is what keeps consecutive words bubble-free.
          if (fifo_re) begin
            sr_next         = fifo_data;
            have_next       = 1'b1;
            sub_next        = '0;
            fetch_left_next = fetch_left_reg - 1'b1;
          end else if (hs) begin
            sub_next = sub_reg + 1'b1;
            if (sub_at_last) begin
              have_next = 1'b0;
            end
          end
          // dout_last implies fetch_left==0, so no pop can collide with this
          if (hs && dout_last) begin
            state_next = ST_IDLE;
            have_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: stream signals and the combinational FIFO pop strobe.
  always_comb begin
    busy        = (state_reg == ST_BUSY);
    sub_at_last = (sub_reg == SUB_LAST);
    dout_valid  = have_reg;
    hs          = have_reg & dout_ready;
    dout_last   = have_reg & (fetch_left_reg == '0) & sub_at_last;
    dout        = have_reg ? chunk[sub_reg] : '0;
    done        = done_reg;
    fifo_re     = busy & fifo_nempty & (fetch_left_reg != '0) &
                  (!have_reg | (hs & sub_at_last));
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed bench for fifo_serializer with a small FIFO
// model on the read side and a handshake monitor on the output stream.
module tb_fifo_serializer;

  localparam int OW = 16;
  localparam int RL = 2;
  localparam int CW = 10;
  localparam int IW = OW << RL;

  localparam logic [OW-1:0] EXP_R [8] = '{16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA,
                                           16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
  localparam logic [OW-1:0] EXP_S [8] = '{16'h0404, 16'h0303, 16'h0202, 16'h0101,
                                           16'hD00D, 16'hCAFE, 16'hBEEF, 16'hF00D};
  localparam logic [OW-1:0] EXP_1 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] len = '0;
  logic          fifo_nempty;
  logic [IW-1:0] fifo_data;
  logic          fifo_re;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  fifo_serializer #(.OUT_WIDTH(OW), .RATIO_LOG(RL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .fifo_nempty(fifo_nempty), .fifo_data(fifo_data), .fifo_re(fifo_re),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes come from the stimulus, pops on fifo_re at posedge
  logic [IW-1:0] fmem [16];
  logic [31:0]   wr_ptr = '0;
  logic [31:0]   rd_ptr = '0;
  logic          fifo_flush = 1'b0;

  assign fifo_nempty = (wr_ptr != rd_ptr);
  assign fifo_data   = fmem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_re && fifo_nempty) rd_ptr <= rd_ptr + 1;
  end

  // Output monitor, sampled mid-cycle
  int          cyc = 0, pop_cnt = 0, re_hs_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int          viol_cnt = 0, stall_err = 0, last_cnt = 0;
  logic [OW-1:0] last_val = '0;
  logic [OW-1:0] prev_dout = '0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] chunk_q [$];
  int            hs_cyc_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dout_valid && dout_ready) begin
      chunk_q.push_back(dout);
      hs_cyc_q.push_back(cyc);
      $display("[TB] t=%0t chunk %h last=%b", $time, dout, dout_last);
      if (dout_last) begin
        last_cnt <= last_cnt + 1;
        last_val <= dout;
      end
      if (fifo_re) re_hs_cnt <= re_hs_cnt + 1;
    end
    if (fifo_re) pop_cnt <= pop_cnt + 1;
    if (fifo_re && !fifo_nempty) viol_cnt <= viol_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (prev_stall && (!dout_valid || dout !== prev_dout)) stall_err <= stall_err + 1;
    prev_stall <= dout_valid && !dout_ready;
    prev_dout  <= dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] w);
    fmem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_start(input logic [CW-1:0] l, input logic ab);
    start = 1'b1;
    len   = l;
    abort = ab;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(output int n, input int max);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({fifo_re, dout, dout_valid, dout_last, busy, done} !== '0) begin
      $display("FAIL reset_outputs: got re=%b dout=%h v=%b l=%b busy=%b done=%b, want all 0",
               fifo_re, dout, dout_valid, dout_last, busy, done);
      fails++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int n, cb, pb, db, lb;
    dout_ready = 1'b1;
    push(64'h4444_3333_2222_1111);
    cb = chunk_q.size(); pb = pop_cnt; db = done_cnt; lb = last_cnt;
    do_start(10'd1, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      $display("FAIL single_busy: got %b want 1", busy); fails++;
    end
    wait_done(n, 40);
    tests++;
    if (n != 6) begin
      $display("FAIL single_done_cycle: got %0d want 6", n); fails++;
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      $display("FAIL single_done_pulse: got %b want 0", done); fails++;
    end
    tick();
    tests++;
    if (chunk_q.size() - cb != 4) begin
      $display("FAIL single_count: got %0d want 4", chunk_q.size() - cb); fails++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (chunk_q[cb+i] !== EXP_1[i]) begin
          $display("FAIL single_chunk%0d: got %h want %h", i, chunk_q[cb+i], EXP_1[i]); fails++;
        end
      end
      tests++;
      if (hs_cyc_q[cb+3] - hs_cyc_q[cb] != 3) begin
        $display("FAIL single_gap: got span %0d want 3", hs_cyc_q[cb+3] - hs_cyc_q[cb]); fails++;
      end
    end
    tests++;
    if (last_cnt - lb != 1 || last_val !== 16'h4444) begin
      $display("FAIL single_last: got %0d lasts val %h want 1 at 4444", last_cnt - lb, last_val); fails++;
    end
    tests++;
    if (pop_cnt - pb != 1 || done_cnt - db != 1) begin
      $display("FAIL single_pop_done: got pops %0d dones %0d want 1 1", pop_cnt - pb, done_cnt - db); fails++;
    end
  endtask

  task automatic test_back_to_back();
    int n, cb, pb, rb, bb;
    dout_ready = 1'b1;
    push(64'h0004_0003_0002_0001);
    push(64'h0008_0007_0006_0005);
    push(64'h000C_000B_000A_0009);
    cb = chunk_q.size(); pb = pop_cnt; rb = re_hs_cnt; bb = busy_cnt;
    do_start(10'd3, 1'b0);
    wait_done(n, 60);
    tests++;
    if (n != 14) begin
      $display("FAIL b2b_done_cycle: got %0d want 14", n); fails++;
    end
    tick();
    tests++;
    if (chunk_q.size() - cb != 12) begin
      $display("FAIL b2b_count: got %0d want 12", chunk_q.size() - cb); fails++;
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests++;
        if (chunk_q[cb+i] !== OW'(i + 1)) begin
          $display("FAIL b2b_chunk%0d: got %h want %h", i, chunk_q[cb+i], OW'(i + 1)); fails++;
        end
      end
      tests++;
      if (hs_cyc_q[cb+11] - hs_cyc_q[cb] != 11) begin
        $display("FAIL b2b_gap: got span %0d want 11", hs_cyc_q[cb+11] - hs_cyc_q[cb]); fails++;
      end
    end
    tests++;
    if (pop_cnt - pb != 3 || re_hs_cnt - rb != 2) begin
      $display("FAIL b2b_pops: got pops %0d on_hs %0d want 3 2", pop_cnt - pb, re_hs_cnt - rb); fails++;
    end
    tests++;
    if (busy_cnt - bb != 13) begin
      $display("FAIL b2b_busy_cycles: got %0d want 13", busy_cnt - bb); fails++;
    end
  endtask

  task automatic test_random_ready();
    int cb, db, sb;
    logic seen;
    push(64'hAAAA_BBBB_CCCC_DDDD);
    push(64'h1234_5678_9ABC_DEF0);
    cb = chunk_q.size(); db = done_cnt; sb = stall_err;
    seen = 1'b0;
    dout_ready = 1'b0;
    do_start(10'd2, 1'b0);
    for (int i = 0; i < 200; i++) begin
      dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    dout_ready = 1'b1;
    tests++;
    if (seen !== 1'b1) begin
      $display("FAIL rand_timeout: got done=%b want 1", seen); fails++;
    end
    tests++;
    if (chunk_q.size() - cb != 8) begin
      $display("FAIL rand_count: got %0d want 8", chunk_q.size() - cb); fails++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (chunk_q[cb+i] !== EXP_R[i]) begin
          $display("FAIL rand_chunk%0d: got %h want %h", i, chunk_q[cb+i], EXP_R[i]); fails++;
        end
      end
    end
    repeat (3) tick();
    tests++;
    if (done_cnt - db != 1 || stall_err - sb != 0) begin
      $display("FAIL rand_done_stall: got dones %0d stall_errs %0d want 1 0",
               done_cnt - db, stall_err - sb); fails++;
    end
  endtask

  task automatic test_starved();
    int cb, vb;
    logic seen;
    cb = chunk_q.size(); vb = viol_cnt;
    seen = 1'b0;
    dout_ready = 1'b1;
    do_start(10'd2, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) push(64'h0101_0202_0303_0404);
      if (i == 20) push(64'hF00D_BEEF_CAFE_D00D);
      @(negedge clk);
      if (i == 3 || i == 15) begin
        tests++;
        if (dout_valid !== 1'b0 || busy !== 1'b1) begin
          $display("FAIL starve_valid_i%0d: got valid=%b busy=%b want 0 1", i, dout_valid, busy); fails++;
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    tests++;
    if (seen !== 1'b1) begin
      $display("FAIL starve_timeout: got done=%b want 1", seen); fails++;
    end
    tests++;
    if (viol_cnt - vb != 0) begin
      $display("FAIL starve_re_empty: got %0d pops from empty want 0", viol_cnt - vb); fails++;
    end
    tests++;
    if (chunk_q.size() - cb != 8) begin
      $display("FAIL starve_count: got %0d want 8", chunk_q.size() - cb); fails++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (chunk_q[cb+i] !== EXP_S[i]) begin
          $display("FAIL starve_chunk%0d: got %h want %h", i, chunk_q[cb+i], EXP_S[i]); fails++;
        end
      end
    end
  endtask

  task automatic test_len_zero();
    int n, pb, bb, db, cb;
    dout_ready = 1'b1;
    pb = pop_cnt; bb = busy_cnt;
    do_start(10'd0, 1'b0);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL len0_done: got done=%b busy=%b want 1 0", done, busy); fails++;
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      $display("FAIL len0_pulse: got %b want 0", done); fails++;
    end
    tick();
    tests++;
    if (pop_cnt - pb != 0 || busy_cnt - bb != 0) begin
      $display("FAIL len0_quiet: got pops %0d busy %0d want 0 0", pop_cnt - pb, busy_cnt - bb); fails++;
    end
    // start while busy must not reload len
    push(64'h0004_0003_0002_0001);
    push(64'h0008_0007_0006_0005);
    cb = chunk_q.size(); pb = pop_cnt; db = done_cnt;
    do_start(10'd2, 1'b0);
    tick();
    do_start(10'd5, 1'b0);
    wait_done(n, 60);
    tests++;
    if (done !== 1'b1) begin
      $display("FAIL busy_start_timeout: got done=%b want 1", done); fails++;
    end
    repeat (5) tick();
    tests++;
    if (chunk_q.size() - cb != 8 || pop_cnt - pb != 2 || done_cnt - db != 1 || busy !== 1'b0) begin
      $display("FAIL busy_start_ignored: got chunks %0d pops %0d dones %0d busy %b want 8 2 1 0",
               chunk_q.size() - cb, pop_cnt - pb, done_cnt - db, busy); fails++;
    end
  endtask

  task automatic test_abort();
    int pb, db;
    dout_ready = 1'b1;
    push(64'h0000_0000_0000_0001);
    push(64'h0000_0000_0000_0002);
    push(64'h0000_0000_0000_0003);
    push(64'h0000_0000_0000_0004);
    pb = pop_cnt; db = done_cnt;
    do_start(10'd4, 1'b0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      $display("FAIL abort_stop: got busy=%b valid=%b want 0 0", busy, dout_valid); fails++;
    end
    repeat (5) tick();
    tests++;
    if (done_cnt - db != 0 || pop_cnt - pb != 1 || (wr_ptr - rd_ptr) != 32'd3) begin
      $display("FAIL abort_state: got dones %0d pops %0d left %0d want 0 1 3",
               done_cnt - db, pop_cnt - pb, wr_ptr - rd_ptr); fails++;
    end
    // abort together with start cancels the command
    pb = pop_cnt; db = done_cnt;
    do_start(10'd1, 1'b1);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL abort_start_busy: got %b want 0", busy); fails++;
    end
    repeat (4) tick();
    tests++;
    if (pop_cnt - pb != 0 || done_cnt - db != 0) begin
      $display("FAIL abort_start_quiet: got pops %0d dones %0d want 0 0", pop_cnt - pb, done_cnt - db); fails++;
    end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b1;
    do_start(10'd3, 1'b0);
    tick();
    tests++;
    if (dout_valid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL rstmid_active: got valid=%b busy=%b want 1 1", dout_valid, busy); fails++;
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({fifo_re, dout, dout_valid, dout_last, busy, done} !== '0) begin
      $display("FAIL rstmid_clear: got re=%b dout=%h v=%b l=%b busy=%b done=%b, want all 0",
               fifo_re, dout, dout_valid, dout_last, busy, done);
      fails++;
    end
    tick();
    rst_n = 1'b1;
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      $display("FAIL rstmid_after: got busy=%b valid=%b want 0 0", busy, dout_valid); fails++;
    end
  endtask

  task automatic test_global();
    tests++;
    if (viol_cnt != 0 || stall_err != 0) begin
      $display("FAIL global_protocol: got empty_pops %0d stall_errs %0d want 0 0", viol_cnt, stall_err); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_ready();
    test_starved();
    test_len_zero();
    test_abort();
    test_reset_mid();
    test_global();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
